// File: rtl/udp_pkg.sv
// Shared widths and the arbiter state encoding for the UDP ingress path.
package udp_pkg;
    localparam int BYTE_W     = 8;
    localparam int UDP_PORT_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_XFER = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_t;
endpackage

// File: rtl/udp_rr_pick.sv
// Rotating-priority picker: returns the first set request at or after ptr,
// wrapping from N_SRC-1 back to 0.
module udp_rr_pick #(
    parameter int N_SRC = 4,
    parameter int SRC_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic [SRC_W-1:0] pick,
    output logic             any_req
);
    int idx;

    // Scan from the farthest offset down so the nearest request is assigned last.
    always_comb begin
        pick = '0;
        idx  = 0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            if (req[idx[SRC_W-1:0]]) begin
                pick = idx[SRC_W-1:0];
            end
        end
    end

    assign any_req = |req;
endmodule

// File: rtl/udp_ingress_arbiter.sv
// Shares one UDP parser among N_SRC byte-stream sources: whole-packet
// round-robin grants, per-source target port, and a forced idle gap after each packet.
module udp_ingress_arbiter
    import udp_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_SRC*BYTE_W-1:0]     src_data,
    input  logic [N_SRC-1:0]            src_valid,
    input  logic [N_SRC-1:0]            src_start,
    input  logic [N_SRC-1:0]            src_last,
    output logic [N_SRC-1:0]            src_ready,
    input  logic [N_SRC*UDP_PORT_W-1:0] src_target_port,
    output logic [BYTE_W-1:0]           parser_data,
    output logic                        parser_valid,
    output logic                        parser_packet_start,
    input  logic                        parser_ready,
    output logic [UDP_PORT_W-1:0]       parser_target_port,
    output logic [$clog2(N_SRC)-1:0]    cur_src,
    output logic                        busy,
    output logic                        stray_err
);
    localparam int SRC_W = $clog2(N_SRC);

    // Handshake: a byte moves on any cycle where valid and ready are both high;
    // valid never waits on ready, and a held byte stays put until accepted.

    arb_state_t             state, next_state;
    logic [SRC_W-1:0]       gnt, rr_ptr, pick, rr_next;
    logic [7:0]             gap_cnt;
    logic [UDP_PORT_W-1:0]  port_q;
    logic                   stray_q, stray_any, any_req, do_grant;
    logic [N_SRC-1:0]       req;
    logic [BYTE_W-1:0]      sel_data;
    logic                   sel_valid, sel_start, sel_last;

    assign req = src_valid & src_start;

    udp_rr_pick #(.N_SRC(N_SRC), .SRC_W(SRC_W)) u_pick (
        .req     (req),
        .ptr     (rr_ptr),
        .pick    (pick),
        .any_req (any_req)
    );

    assign rr_next   = (pick == SRC_W'(N_SRC - 1)) ? '0 : pick + 1'b1;
    assign sel_data  = src_data[BYTE_W*gnt +: BYTE_W];
    assign sel_valid = src_valid[gnt];
    assign sel_start = src_start[gnt];
    assign sel_last  = src_last[gnt];

    always_comb begin
        next_state          = state;
        src_ready           = '0;
        parser_data         = '0;
        parser_valid        = 1'b0;
        parser_packet_start = 1'b0;
        do_grant            = 1'b0;
        stray_any           = 1'b0;
        case (state)
            ARB_IDLE: begin
                // Bytes that cannot open a packet are drained so they never block a source.
                src_ready = src_valid & ~src_start;
                stray_any = |(src_valid & ~src_start);
                if (any_req) begin
                    do_grant   = 1'b1;
                    next_state = ARB_XFER;
                end
            end
            ARB_XFER: begin
                parser_data         = sel_data;
                parser_valid        = sel_valid;
                parser_packet_start = sel_valid & sel_start;
                src_ready[gnt]      = parser_ready;
                if (sel_valid && parser_ready && sel_last) begin
                    next_state = (GAP_CYCLES == 0) ? ARB_IDLE : ARB_GAP;
                end
            end
            ARB_GAP: begin
                if (gap_cnt <= 8'd1) begin
                    next_state = ARB_IDLE;
                end
            end
            default: next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            gnt     <= '0;
            rr_ptr  <= '0;
            gap_cnt <= '0;
            port_q  <= '0;
            stray_q <= 1'b0;
        end else begin
            state   <= next_state;
            stray_q <= stray_any;
            if (do_grant) begin
                gnt    <= pick;
                rr_ptr <= rr_next;
                port_q <= src_target_port[UDP_PORT_W*pick +: UDP_PORT_W];
            end
            if (state == ARB_XFER && next_state == ARB_GAP) begin
                gap_cnt <= 8'(GAP_CYCLES);
            end else if (state == ARB_GAP) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

    assign parser_target_port = port_q;
    assign cur_src            = gnt;
    assign busy               = (state != ARB_IDLE);
    assign stray_err          = stray_q;
endmodule

// File: tb/tb_udp_ingress_arbiter.sv
// Bench for udp_ingress_arbiter: IDLE-cycle vector table, hand-written reset
// sequence, and packet streams scored against a round-robin packet-order model.
module tb_udp_ingress_arbiter;
    localparam int N   = 4;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] src_data;
    logic [3:0]  src_valid, src_start, src_last, src_ready;
    logic [63:0] src_target_port;
    logic [7:0]  parser_data;
    logic        parser_valid, parser_packet_start, parser_ready;
    logic [15:0] parser_target_port;
    logic [1:0]  cur_src;
    logic        busy, stray_err;

    udp_ingress_arbiter #(.N_SRC(N), .GAP_CYCLES(GAP)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .src_data            (src_data),
        .src_valid           (src_valid),
        .src_start           (src_start),
        .src_last            (src_last),
        .src_ready           (src_ready),
        .src_target_port     (src_target_port),
        .parser_data         (parser_data),
        .parser_valid        (parser_valid),
        .parser_packet_start (parser_packet_start),
        .parser_ready        (parser_ready),
        .parser_target_port  (parser_target_port),
        .cur_src             (cur_src),
        .busy                (busy),
        .stray_err           (stray_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] start;
        logic [3:0] exp_ready;
        logic       exp_busy;
        logic [1:0] exp_cur;
        logic       exp_stray;
    } vec_t;

    vec_t        vecs[8];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] port_tab[4];
    logic [9:0]  src_q[4][$];   // {start, last, data} per pending byte
    int          pkt_q[4][$];   // packet lengths per source
    logic [27:0] exp_q[$];      // {last, start, src, port, data}
    int          model_ptr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; src_valid = '0; src_start = '0; src_last = '0; src_data = '0;
        parser_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_ptr = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_cur"},    32'(cur_src), 32'd0);
        check({tag, "_port"},   32'(parser_target_port), 32'd0);
        check({tag, "_pvalid"}, 32'(parser_valid), 32'd0);
        check({tag, "_pdata"},  32'(parser_data), 32'd0);
        check({tag, "_pstart"}, 32'(parser_packet_start), 32'd0);
        check({tag, "_stray"},  32'(stray_err), 32'd0);
        check({tag, "_ready"},  32'(src_ready), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic add_packet(input int s, input int len);
        for (int j = 0; j < len; j++) begin
            src_q[s].push_back({(j == 0), (j == len - 1), 8'($urandom_range(0, 255))});
        end
        pkt_q[s].push_back(len);
    endtask

    // Every source keeps its next start byte presented, so packets are served
    // in pure round-robin order regardless of timing.
    task automatic build_expected();
        int pos[4];
        int pi[4];
        int left;
        bit found;
        left = 0;
        for (int i = 0; i < 4; i++) begin
            pos[i] = 0; pi[i] = 0; left += pkt_q[i].size();
        end
        while (left > 0) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (model_ptr + k) % 4;
                if (!found && pi[idx] < pkt_q[idx].size()) begin
                    int len;
                    len = pkt_q[idx][pi[idx]];
                    for (int j = 0; j < len; j++) begin
                        logic [9:0] b;
                        b = src_q[idx][pos[idx] + j];
                        exp_q.push_back({(j == len - 1), (j == 0), 2'(idx), port_tab[idx], b[7:0]});
                    end
                    pos[idx] += len;
                    pi[idx]++;
                    left--;
                    model_ptr = (idx + 1) % 4;
                    found = 1'b1;
                end
            end
        end
        for (int i = 0; i < 4; i++) pkt_q[i].delete();
    endtask

    // stall_at < 0: random parser_ready; otherwise ready drops for 3 cycles at that byte index.
    task automatic run_stream(input int stall_at);
        int          cyc = 0, nxfer = 0, stall_left = 3, idle_run = 0;
        bit          seen_last = 1'b0;
        logic [27:0] e;
        logic [3:0]  pop;
        src_target_port = {port_tab[3], port_tab[2], port_tab[1], port_tab[0]};
        while ((exp_q.size() > 0 || src_q[0].size() + src_q[1].size() +
                src_q[2].size() + src_q[3].size() > 0) && cyc < 2000) begin
            for (int i = 0; i < 4; i++) begin
                if (src_q[i].size() > 0) begin
                    {src_start[i], src_last[i], src_data[8*i +: 8]} = src_q[i][0];
                    src_valid[i] = 1'b1;
                end else begin
                    src_start[i] = 1'b0; src_last[i] = 1'b0; src_valid[i] = 1'b0;
                    src_data[8*i +: 8] = 8'h00;
                end
            end
            if (stall_at < 0) parser_ready = ($urandom_range(0, 3) != 0);
            else if (nxfer == stall_at && stall_left > 0) begin
                parser_ready = 1'b0; stall_left--;
            end else parser_ready = 1'b1;
            @(negedge clk);
            if (cyc == 1) check("grant_latency", 32'(parser_valid), 32'd1);
            if (!parser_ready) check("stall_ready", 32'(src_ready), 32'd0);
            if (parser_valid && seen_last) begin
                check("gap_len", 32'(idle_run), 32'(GAP + 1));
                seen_last = 1'b0;
            end
            if (!parser_valid) idle_run++;
            pop = src_valid & src_ready;
            if (parser_valid && parser_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL extra_xfer actual=0x%0h required=none", parser_data);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer", 32'({parser_packet_start, cur_src, parser_target_port, parser_data}),
                          32'(e[26:0]));
                    check("xfer_pop", 32'(pop), 32'(4'b0001 << e[25:24]));
                    if (e[27]) begin seen_last = 1'b1; idle_run = 0; end
                end
                nxfer++;
            end else begin
                check("no_pop", 32'(pop), 32'd0);
            end
            @(posedge clk);
            for (int i = 0; i < 4; i++) if (pop[i]) void'(src_q[i].pop_front());
            #1;
            cyc++;
        end
        src_valid = '0; src_start = '0; src_last = '0; src_data = '0; parser_ready = 1'b1;
        if (cyc >= 2000) begin
            checks++; failures++;
            $display("FAIL stream_timeout actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
            for (int i = 0; i < 4; i++) src_q[i].delete();
        end else begin
            for (int g = 0; g < GAP; g++) begin
                @(negedge clk); check("gap_busy", 32'(busy), 32'd1);
                @(posedge clk); #1;
            end
            @(negedge clk); check("gap_done", 32'(busy), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b0; src_valid = '0; src_start = '0; src_last = '0; src_data = '0;
        parser_ready = 1'b1;
        port_tab = '{16'h0035, 16'h0044, 16'h1F90, 16'h01BB};
        src_target_port = {port_tab[3], port_tab[2], port_tab[1], port_tab[0]};
        //          valid    start    exp_ready busy cur  stray
        vecs[0] = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b0};
        vecs[1] = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0};
        vecs[2] = '{4'b1010, 4'b1010, 4'b0000, 1'b1, 2'd1, 1'b0};
        vecs[3] = '{4'b0010, 4'b0000, 4'b0010, 1'b0, 2'd0, 1'b1};
        vecs[4] = '{4'b1110, 4'b1000, 4'b0110, 1'b1, 2'd3, 1'b1};
        vecs[5] = '{4'b1111, 4'b1111, 4'b0000, 1'b1, 2'd0, 1'b0};
        vecs[6] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[7] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};

        do_reset();
        check_idle_outputs("reset");

        for (int v = 0; v < 8; v++) begin
            do_reset();
            src_valid = vecs[v].valid; src_start = vecs[v].start; src_data = 32'h44332211;
            @(negedge clk);
            check("tbl_ready",  32'(src_ready), 32'(vecs[v].exp_ready));
            check("tbl_pvalid", 32'(parser_valid), 32'd0);
            @(posedge clk); #1;
            src_valid = '0; src_start = '0;
            @(negedge clk);
            check("tbl_busy",  32'(busy), 32'(vecs[v].exp_busy));
            check("tbl_cur",   32'(cur_src), 32'(vecs[v].exp_cur));
            check("tbl_stray", 32'(stray_err), 32'(vecs[v].exp_stray));
            check("tbl_port",  32'(parser_target_port),
                  vecs[v].exp_busy ? 32'(port_tab[vecs[v].exp_cur]) : 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check("tbl_stray_once", 32'(stray_err), 32'd0);
            @(posedge clk); #1;
        end

        // Single 10-byte packet, then the same under a 3-cycle stall at byte 4.
        do_reset();
        add_packet(0, 10); build_expected(); run_stream(1000);
        add_packet(0, 10); build_expected(); run_stream(4);

        // src0 and src2 together, then src1 and src0 together with the pointer at 3.
        do_reset();
        add_packet(0, 4); add_packet(2, 3); build_expected(); run_stream(1000);
        add_packet(1, 2); add_packet(0, 1); build_expected(); run_stream(1000);

        // All four sources back-to-back with distinct target ports; src0 twice.
        do_reset();
        add_packet(0, 3); add_packet(0, 2); add_packet(1, 3); add_packet(2, 1); add_packet(3, 4);
        build_expected(); run_stream(1000);

        // Reset in the middle of a packet; pointer must return to 0.
        do_reset();
        src_valid = 4'b0010; src_start = 4'b0010; src_data = 32'h0000A100; parser_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        src_start = '0; src_data = 32'h0000A200;
        @(negedge clk);
        check("mid_cur",  32'(cur_src), 32'd1);
        check("mid_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; src_valid = '0; src_start = '0; src_data = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_outputs("mid_rst");
        src_valid = 4'b1111; src_start = 4'b1111;
        @(posedge clk); #1;
        src_valid = '0; src_start = '0;
        @(negedge clk);
        check("rr_after_rst", 32'(cur_src), 32'd0);
        check("rr_after_rst_port", 32'(parser_target_port), 32'(port_tab[0]));
        @(posedge clk); #1;

        // Randomized rounds: random lengths (including 1-byte), data, ports, backpressure.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < 4; s++) port_tab[s] = 16'($urandom_range(0, 65535));
            for (int s = 0; s < 4; s++) begin
                for (int p = 0; p < 3; p++) add_packet(s, $urandom_range(1, 8));
            end
            build_expected();
            run_stream(-1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
